// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared registered ALU; one operation in flight at a time.
// Accept -> resp_valid after ALU_LAT+2 cycles; response held until resp_ready.
module alu_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [1:0]  req0_ctrl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req1_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_ctrl,
  input  logic [31:0] alu_r,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  input  logic        alu_branch,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_r,
  output logic        resp_zero,
  output logic        resp_ovf,
  output logic        resp_branch,
  output logic [15:0] op_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAST_CNT = 4'(ALU_LAT);

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [1:0]  alu_ctrl_q, alu_ctrl_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q, resp_id_d;
  logic [31:0] resp_r_q, resp_r_d;
  logic        resp_zero_q, resp_zero_d;
  logic        resp_ovf_q, resp_ovf_d;
  logic        resp_branch_q, resp_branch_d;
  logic [15:0] op_cnt_q, op_cnt_d;

  logic grant_vld;
  logic grant_id;
  logic accept;

  // prio only breaks ties; a lone requester always wins
  always_comb begin
    grant_vld  = req0_valid | req1_valid;
    grant_id   = (req0_valid & req1_valid) ? prio_q : req1_valid;
    accept     = !reset && (state_q == IDLE) && grant_vld;
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
  end

  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    cnt_d         = cnt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_ctrl_d    = alu_ctrl_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_r_d      = resp_r_q;
    resp_zero_d   = resp_zero_q;
    resp_ovf_d    = resp_ovf_q;
    resp_branch_d = resp_branch_q;
    op_cnt_d      = op_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_a_d    = grant_id ? req1_a    : req0_a;
          alu_b_d    = grant_id ? req1_b    : req0_b;
          alu_ctrl_d = grant_id ? req1_ctrl : req0_ctrl;
          prio_d     = ~grant_id;
          resp_id_d  = grant_id;
          cnt_d      = 4'd0;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        // the extra cycle beyond ALU_LAT lets the registered ALU output settle before capture
        if (cnt_q == LAST_CNT) begin
          resp_r_d      = alu_r;
          resp_zero_d   = alu_zero;
          resp_ovf_d    = alu_ovf;
          resp_branch_d = alu_branch;
          resp_valid_d  = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          op_cnt_d     = op_cnt_q + 16'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      prio_q        <= 1'b0;
      cnt_q         <= 4'd0;
      alu_a_q       <= 32'd0;
      alu_b_q       <= 32'd0;
      alu_ctrl_q    <= 2'd0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_r_q      <= 32'd0;
      resp_zero_q   <= 1'b0;
      resp_ovf_q    <= 1'b0;
      resp_branch_q <= 1'b0;
      op_cnt_q      <= 16'd0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      cnt_q         <= cnt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_ctrl_q    <= alu_ctrl_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_r_q      <= resp_r_d;
      resp_zero_q   <= resp_zero_d;
      resp_ovf_q    <= resp_ovf_d;
      resp_branch_q <= resp_branch_d;
      op_cnt_q      <= op_cnt_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_r      = resp_r_q;
  assign resp_zero   = resp_zero_q;
  assign resp_ovf    = resp_ovf_q;
  assign resp_branch = resp_branch_q;
  assign op_cnt      = op_cnt_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL take parameter ALU_LAT, default 1, range 1..15: the ALU register latency in cycles, from operands applied to R/zero/ovf/branch valid.
REQ-002 The block SHALL have one clock and synchronous, active-high reset; the ports SHALL be as listed below.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-006 reqN_ready  output  1  arbiter accepts requester N this cycle.
REQ-007 reqN_a, reqN_b  input  32 each  operands of requester N.
REQ-008 reqN_ctrl  input  2  ALU operation code of requester N, passed through unmodified.
REQ-009 alu_a, alu_b  output  32 each  registered operands driven to the shared ALU A/B.
REQ-010 alu_ctrl  output  2  registered operation code driven to ALU CTRL.
REQ-011 alu_r  input  32  ALU result R.
REQ-012 alu_zero, alu_ovf, alu_branch  input  1 each  ALU status flags.
REQ-013 resp_valid  output  1  response holding.
REQ-014 resp_ready  input  1  consumer takes response.
REQ-015 resp_id  output  1  requester index the response belongs to.
REQ-016 resp_r  output  32  captured result.
REQ-017 resp_zero, resp_ovf, resp_branch  output  1 each  captured flags.
REQ-018 op_cnt  output  16  count of completed responses.

Function
REQ-019 The FSM SHALL have states IDLE, EXEC and RESP; exactly one operation is in flight at any time.
REQ-020 reqN_ready SHALL be combinational: high only in IDLE when requester N holds the grant; it is never high in EXEC or RESP.
REQ-021 The grant SHALL follow these rules: only one valid -> that requester; both valid -> the requester selected by prio bit; none -> no grant.
REQ-022 On accept (reqN_valid & reqN_ready at edge T), the block SHALL capture a/b/ctrl into alu_a/alu_b/alu_ctrl, set prio to the other requester, latch the id, and enter EXEC.
REQ-023 prio SHALL change only on accept; a single valid requester winning does not preserve its priority.
REQ-024 The block SHALL stay in EXEC for exactly ALU_LAT+1 cycles, counted by a 4-bit counter cleared on entry.
REQ-025 On the last EXEC edge, the block SHALL capture alu_r/zero/ovf/branch into resp_*, set resp_valid, and enter RESP.
REQ-026 Timing: with an accept at edge T, resp_valid SHALL first be high in cycle T+ALU_LAT+2.
REQ-027 alu_a/alu_b/alu_ctrl SHALL hold their values in EXEC, RESP and IDLE until the next accept.
REQ-028 In RESP, resp_* and resp_id SHALL be stable until resp_valid & resp_ready.
REQ-029 On the RESP handshake edge, the block SHALL clear resp_valid, increment op_cnt (0xFFFF wraps to 0x0000), and return to IDLE.
REQ-030 No new accept SHALL occur in the RESP handshake cycle; the earliest next accept is the following IDLE cycle.
REQ-031 If resp_ready is held high, the back-to-back issue interval SHALL be ALU_LAT+3 cycles.
REQ-032 Requester inputs SHALL be ignored outside the accept cycle; dropping reqN_valid without ready has no effect.

Reset
REQ-033 While reset is high at an edge, the block SHALL set: state IDLE, prio 0, counter 0, alu_a/alu_b 0, alu_ctrl 0, resp_valid 0, resp_id 0, resp_r 0, resp flags 0, op_cnt 0.
REQ-034 Reset in EXEC or RESP SHALL discard the in-flight operation without producing a response.
REQ-035 While reset is high, reqN_ready SHALL be 0.

Verification
Bench ALU stub: registered, ALU_LAT=1; R=A+B; zero=(R==0).
REQ-036 Scenario 1: after reset, req0 only, a=5, b=7, ctrl=0 -> req0_ready at T, resp_valid at T+3, resp_r=12, resp_id=0, resp_zero=0.
REQ-037 Scenario 2: both valid from reset, resp_ready=1 -> grants alternate 0,1,0,1; issue spacing 4 cycles; op_cnt=4 after the fourth handshake.
REQ-038 Scenario 3: req1 a=0, b=0, resp_ready=0 for 10 cycles -> resp_valid held, resp_r=0, resp_zero=1, no ready asserted; then completes on resp_ready.
REQ-039 Scenario 4: reset pulsed in EXEC -> no response issued; all outputs are at reset values the next cycle; prio=0.
REQ-040 Scenario 5: op_cnt preloaded via 65535 completions -> the next handshake wraps op_cnt to 0.
REQ-041 Scenario 6: req1 valid alone, then both valid -> req1 accepted first, then req0 wins (prio=0).
